// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute/memory/writeback control sequencer.
// Define CTRL_EBREAK_HALT_EN to make ebreak (0x00100073) park the core in a sticky HALT state.
module ctrl_fsm (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_ifu_rvalid,
  input  logic [31:0] i_ifu_inst,
  input  logic        i_lsu_ready,
  output logic        o_ctrl_ifu_req,
  output logic        o_ctrl_ir_we,
  output logic [31:0] o_ctrl_inst,
  output logic        o_ctrl_lsu_req,
  output logic        o_ctrl_lsu_wen,
  output logic        o_ctrl_reg_we,
  output logic        o_ctrl_pc_we,
  output logic [2:0]  o_ctrl_state,
  output logic        o_ctrl_halt,
  output logic [31:0] o_ctrl_instret
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`ifdef CTRL_EBREAK_HALT_EN
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
`endif

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] inst_r;
  logic [31:0] instret_r;
  logic [31:0] instret_nxt_s;

  logic is_load_s;
  logic is_store_s;
  logic is_branch_s;
  logic is_system_s;

  logic ifu_req_s;
  logic ir_we_s;
  logic lsu_req_s;
  logic lsu_wen_s;
  logic reg_we_s;
  logic pc_we_s;
`ifdef CTRL_EBREAK_HALT_EN
  logic halt_s;
`endif

  assign is_load_s   = (inst_r[6:0] == OPC_LOAD);
  assign is_store_s  = (inst_r[6:0] == OPC_STORE);
  assign is_branch_s = (inst_r[6:0] == OPC_BRANCH);
  assign is_system_s = (inst_r[6:0] == OPC_SYSTEM);

  // Kept as a separate net so the retire counter's next value has a single, observable source.
  assign instret_nxt_s = instret_r + 32'd1;

  // Next-state decode and per-state strobe generation.
  always_comb begin
    state_nxt_s = state_r;
    ifu_req_s   = 1'b0;
    ir_we_s     = 1'b0;
    lsu_req_s   = 1'b0;
    lsu_wen_s   = 1'b0;
    reg_we_s    = 1'b0;
    pc_we_s     = 1'b0;
`ifdef CTRL_EBREAK_HALT_EN
    halt_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ifu_req_s = 1'b1;
        if (i_ifu_rvalid) begin
          ir_we_s     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
`ifdef CTRL_EBREAK_HALT_EN
        if (inst_r == INST_EBREAK) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
`else
        state_nxt_s = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        if (is_load_s || is_store_s) begin
          state_nxt_s = ST_MEM;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req_s = 1'b1;
        lsu_wen_s = is_store_s;
        if (i_lsu_ready) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        pc_we_s     = 1'b1;
        reg_we_s    = !(is_store_s || is_branch_s || is_system_s);
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: begin
`ifdef CTRL_EBREAK_HALT_EN
        halt_s      = 1'b1;
        state_nxt_s = ST_HALT;
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction register and retired-instruction counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inst_r    <= 32'd0;
      instret_r <= 32'd0;
    end else begin
      if (ir_we_s) begin
        inst_r <= i_ifu_inst;
      end
      if (state_r == ST_WB) begin
        instret_r <= instret_nxt_s;
      end
    end
  end

  assign o_ctrl_ifu_req = ifu_req_s;
  assign o_ctrl_ir_we   = ir_we_s;
  assign o_ctrl_inst    = inst_r;
  assign o_ctrl_lsu_req = lsu_req_s;
  assign o_ctrl_lsu_wen = lsu_wen_s;
  assign o_ctrl_reg_we  = reg_we_s;
  assign o_ctrl_pc_we   = pc_we_s;
  assign o_ctrl_state   = state_r;
  assign o_ctrl_instret = instret_r;
`ifdef CTRL_EBREAK_HALT_EN
  assign o_ctrl_halt    = halt_s;
`else
  assign o_ctrl_halt    = 1'b0;
`endif

endmodule
